// File: rtl/trivium_pkg.sv
// trivium_pkg: shared widths, tap positions, FSM encoding and the single-step Trivium update
package trivium_pkg;
  localparam int KEY_BITS = 80;
  localparam int IV_BITS  = 80;
  localparam int ST_BITS  = 288;
  localparam int T1_A = 66,  T1_B = 93;
  localparam int T2_A = 162, T2_B = 177;
  localparam int T3_A = 243, T3_B = 288;
  localparam int A1_X = 91,  A1_Y = 92,  F1 = 171;
  localparam int A2_X = 175, A2_Y = 176, F2 = 264;
  localparam int A3_X = 286, A3_Y = 287, F3 = 69;
  typedef enum logic [2:0] {IDLE, LOAD, INIT, RUN, EXHAUST} state_e;
  // Vector bit i-1 holds s_i; returns {z, next state}. Registers are s1..s93, s94..s177, s178..s288.
  function automatic logic [ST_BITS:0] triv_step(input logic [ST_BITS-1:0] s);
    logic t1, t2, t3, z;
    t1 = s[T1_A-1] ^ s[T1_B-1];
    t2 = s[T2_A-1] ^ s[T2_B-1];
    t3 = s[T3_A-1] ^ s[T3_B-1];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (s[A1_X-1] & s[A1_Y-1]) ^ s[F1-1];
    t2 = t2 ^ (s[A2_X-1] & s[A2_Y-1]) ^ s[F2-1];
    t3 = t3 ^ (s[A3_X-1] & s[A3_Y-1]) ^ s[F3-1];
    return {z, s[286:177], t2, s[175:93], t1, s[91:0], t3};
  endfunction
endpackage

// File: rtl/trivium_unroll.sv
// trivium_unroll: combinational W-step Trivium update; o_z[W-1] is the earliest keystream bit
module trivium_unroll import trivium_pkg::*; #(
  parameter int W = 8
) (
  input  logic [ST_BITS-1:0] i_s,
  output logic [ST_BITS-1:0] o_s,
  output logic [W-1:0]       o_z
);
  logic [ST_BITS-1:0] w_s;
  logic               w_b;
  // Chain W single steps, collecting keystream bits MSB-first
  always_comb begin
    w_s = i_s;
    w_b = 1'b0;
    o_z = '0;
    for (int i = 0; i < W; i++) begin
      {w_b, w_s} = triv_step(w_s);
      o_z[W-1-i] = w_b;
    end
  end
  assign o_s = w_s;
endmodule

// File: rtl/trivium_stream_w.sv
// trivium_stream_w: byte-loaded Trivium core with W-bit valid/ready keystream XOR datapath
module trivium_stream_w import trivium_pkg::*; #(
  parameter int W          = 8,
  parameter int INIT_RNDS  = 1152,
  parameter int WORD_LIMIT = 2**20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_wr,
  input  logic         iv_wr,
  input  logic [7:0]   kb_in,
  input  logic         start,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  output logic [2:0]   state_o,
  output logic         err
);
  localparam int INIT_CYC = INIT_RNDS / W;
  localparam int IC_W     = $clog2(INIT_CYC + 1);
  localparam int WC_W     = $clog2(WORD_LIMIT + 1);
  state_e               r_state;
  logic [KEY_BITS-1:0]  r_key;
  logic [IV_BITS-1:0]   r_iv;
  logic [3:0]           r_key_cnt, r_iv_cnt;
  logic [ST_BITS-1:0]   r_s;
  logic [IC_W-1:0]      r_init_cnt;
  logic [WC_W-1:0]      r_word_cnt;
  logic                 r_m_valid, r_err;
  logic [W-1:0]         r_m_data;
  logic [ST_BITS-1:0]   w_ns;
  logic [W-1:0]         w_z;
  logic [IV_BITS-1:0]   w_iv;
  logic                 w_wr, w_acc, w_start_ok, w_err;
  trivium_unroll #(.W(W)) u_unroll (.i_s(r_s), .o_s(w_ns), .o_z(w_z));
  assign w_wr       = key_wr | iv_wr;
  assign w_start_ok = r_state == LOAD && r_key_cnt == 4'd10 && (r_iv_cnt == 4'd0 || r_iv_cnt == 4'd10);
  assign w_iv       = r_iv_cnt == 4'd0 ? '0 : r_iv;
  assign w_err      = (key_wr & iv_wr) | (key_wr & r_key_cnt == 4'd10) |
                      (iv_wr & !key_wr & r_iv_cnt == 4'd10) | (start & !w_wr & !w_start_ok);
  assign s_ready    = r_state == RUN && (!r_m_valid || m_ready);
  assign w_acc      = s_valid & s_ready;
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign state_o    = r_state;
  assign err        = r_err;
  // FSM: byte loading, warm-up, streaming and budget tracking; byte writes always win and abort a session
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_key      <= '0;
      r_iv       <= '0;
      r_key_cnt  <= '0;
      r_iv_cnt   <= '0;
      r_s        <= '0;
      r_init_cnt <= '0;
      r_word_cnt <= '0;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_err;
      if (w_wr) begin
        if (key_wr && r_key_cnt != 4'd10) begin
          r_key     <= {r_key[KEY_BITS-9:0], kb_in};
          r_key_cnt <= r_key_cnt + 4'd1;
        end
        if (iv_wr && !key_wr && r_iv_cnt != 4'd10) begin
          r_iv     <= {r_iv[IV_BITS-9:0], kb_in};
          r_iv_cnt <= r_iv_cnt + 4'd1;
        end
        r_state    <= LOAD;
        r_init_cnt <= '0;
        r_word_cnt <= '0;
        if (r_state == INIT || r_state == RUN) begin
          r_s       <= '0;
          r_m_valid <= 1'b0;
        end else if (m_ready) r_m_valid <= 1'b0;
      end else if (start && w_start_ok) begin
        r_s        <= {3'b111, 112'b0, w_iv, 13'b0, r_key};
        r_key_cnt  <= '0;
        r_iv_cnt   <= '0;
        r_init_cnt <= '0;
        r_state    <= INIT;
        if (m_ready) r_m_valid <= 1'b0;
      end else if (r_state == INIT) begin
        r_s        <= w_ns;
        r_init_cnt <= r_init_cnt + IC_W'(1);
        if (r_init_cnt == IC_W'(INIT_CYC - 1)) r_state <= RUN;
        if (m_ready) r_m_valid <= 1'b0;
      end else if (w_acc) begin
        r_s        <= w_ns;
        r_m_data   <= s_data ^ w_z;
        r_m_valid  <= 1'b1;
        r_word_cnt <= r_word_cnt + WC_W'(1);
        if (r_word_cnt == WC_W'(WORD_LIMIT - 1)) r_state <= EXHAUST;
      end else if (m_ready) r_m_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_trivium_stream_w.sv
// tb_trivium_stream_w: table-driven load protocol plus randomized streaming against a bit-level Trivium model
module tb_trivium_stream_w;
  import trivium_pkg::*;
  localparam int W     = 8;
  localparam int LIM   = 300;
  localparam int NINIT = 1152 / W;
  typedef struct {
    bit         kw;
    bit         iw;
    bit         st;
    logic [7:0] kb;
    logic [2:0] exp_state;
    bit         exp_err;
  } vec_t;
  logic         clk = 1'b0, rst = 1'b0, key_wr = 1'b0, iv_wr = 1'b0, start = 1'b0;
  logic         s_valid = 1'b0, m_ready = 1'b0;
  logic [7:0]   kb_in = '0;
  logic [W-1:0] s_data = '0;
  logic         s_ready, m_valid, err;
  logic [W-1:0] m_data;
  logic [2:0]   state_o;
  int           errors = 0, checks = 0;
  bit           ks[$];
  vec_t         tbl[$];
  logic [W-1:0] q[$];
  logic [W-1:0] held;
  logic [79:0]  key1 = '0, iv1 = '0, key2 = '0;
  logic [7:0]   b;
  bit           stall, exp_sr, exh;
  int           nacc, cyc;

  always #5 clk = ~clk;

  trivium_stream_w #(.W(W), .INIT_RNDS(1152), .WORD_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .key_wr(key_wr), .iv_wr(iv_wr), .kb_in(kb_in), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .state_o(state_o), .err(err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Textbook Trivium with 1-indexed state s1..s288; s_i takes key/IV bit i-1
  function automatic void gen_ks(input logic [79:0] k, input logic [79:0] v, input int n);
    bit s[1:288];
    bit t1, t2, t3;
    ks.delete();
    for (int i = 1; i <= 288; i++) s[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      s[i]      = k[i-1];
      s[93 + i] = v[i-1];
    end
    s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
    for (int r = 0; r < 1152 + n; r++) begin
      t1 = s[66] ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      if (r >= 1152) ks.push_back(t1 ^ t2 ^ t3);
      t1 = t1 ^ (s[91] & s[92]) ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      for (int i = 288; i > 1; i--) s[i] = s[i-1];
      s[1] = t3; s[94] = t1; s[178] = t2;
    end
  endfunction

  function automatic logic [W-1:0] kw(input int n);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[W-1-i] = ks[n*W + i];
    return r;
  endfunction

  function automatic void add(input bit k, input bit v, input bit st, input logic [7:0] d,
                              input logic [2:0] es, input bit ee);
    tbl.push_back('{k, v, st, d, es, ee});
  endfunction

  task automatic wr_key(input logic [7:0] d);
    key_wr = 1'b1;
    kb_in  = d;
    @(negedge clk);
    key_wr = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_init", state_o, INIT);
  endtask

  task automatic wait_run();
    int n = 0;
    while (state_o !== RUN && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("init_cycles", n, NINIT);
  endtask

  task automatic run_fixed(input int n, input bit zero);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      m_ready = 1'b1;
      s_data  = zero ? '0 : W'($urandom);
      #1 chk("run_sready", s_ready, 1);
      @(negedge clk);
      chk("run_valid", m_valid, 1);
      chk($sformatf("run_data%0d", i), m_data, s_data ^ kw(i));
    end
    s_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_state", state_o, IDLE);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_mdata", m_data, 0);
    chk("rst_sready", s_ready, 0);
    chk("rst_err", err, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_state", state_o, IDLE);

    add(0, 0, 1, 8'h00, IDLE, 1);
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom); key1 = {key1[71:0], b}; add(1, 0, 0, b, LOAD, 0);
    end
    add(0, 0, 1, 8'h00, LOAD, 1);
    b = 8'($urandom); key1 = {key1[71:0], b}; add(1, 0, 0, b, LOAD, 0);
    add(1, 0, 0, 8'($urandom), LOAD, 1);
    add(1, 1, 0, 8'($urandom), LOAD, 1);
    b = 8'($urandom); iv1 = {iv1[71:0], b}; add(0, 1, 0, b, LOAD, 0);
    add(0, 0, 1, 8'h00, LOAD, 1);
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom); iv1 = {iv1[71:0], b}; add(0, 1, 0, b, LOAD, 0);
    end
    add(0, 0, 1, 8'h00, INIT, 0);
    foreach (tbl[i]) begin
      key_wr = tbl[i].kw; iv_wr = tbl[i].iw; start = tbl[i].st; kb_in = tbl[i].kb;
      @(negedge clk);
      chk($sformatf("vec%0d_state", i), state_o, tbl[i].exp_state);
      chk($sformatf("vec%0d_err", i), err, tbl[i].exp_err);
    end
    key_wr = 1'b0; iv_wr = 1'b0; start = 1'b0;
    chk("init_sready", s_ready, 0);
    gen_ks(key1, iv1, LIM * W);
    wait_run();

    nacc = 0; exh = 1'b0; stall = 1'b0; cyc = 0;
    while ((nacc < LIM || q.size() != 0) && cyc < 5000) begin
      chk("c_valid", m_valid, q.size() != 0);
      if (q.size() != 0) chk("c_data", m_data, q[0]);
      if (stall) chk("c_stable", m_data, held);
      chk("c_err", err, 0);
      m_ready = $urandom_range(0, 9) >= 3;
      s_valid = $urandom_range(0, 9) >= 2;
      s_data  = W'($urandom);
      #1;
      exp_sr = !exh && (q.size() == 0 || m_ready);
      chk("c_sready", s_ready, exp_sr);
      stall = m_valid && !m_ready;
      held  = m_data;
      if (m_ready && q.size() != 0) void'(q.pop_front());
      if (s_valid && exp_sr) begin
        q.push_back(s_data ^ kw(nacc));
        nacc++;
        exh = nacc == LIM;
      end
      @(negedge clk);
      cyc++;
    end
    chk("c_budget", cyc < 5000, 1);
    chk("exh_state", state_o, EXHAUST);
    s_valid = 1'b1; m_ready = 1'b1;
    #1 chk("exh_sready", s_ready, 0);
    @(negedge clk);
    chk("exh_no_accept", m_valid, 0);
    s_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("exh_start_err", err, 1);
    chk("exh_start_state", state_o, EXHAUST);
    @(negedge clk);
    chk("err_pulse_len", err, 0);

    b = 8'($urandom); wr_key(b);
    chk("exh_wr_load", state_o, LOAD);
    for (int i = 0; i < 9; i++) wr_key(8'($urandom));
    do_start();
    repeat (50) @(negedge clk);
    wr_key(8'h00);
    chk("abort_init_state", state_o, LOAD);
    chk("abort_init_mvalid", m_valid, 0);
    chk("abort_init_err", err, 0);
    for (int i = 0; i < 9; i++) wr_key(8'h00);
    do_start();
    wait_run();
    gen_ks('0, '0, 64 * W);
    run_fixed(64, 1'b1);

    m_ready = 1'b0;
    b = 8'($urandom);
    key2 = {72'h0, b};
    wr_key(b);
    chk("abort_run_state", state_o, LOAD);
    chk("abort_run_mvalid", m_valid, 0);
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom); key2 = {key2[71:0], b}; wr_key(b);
    end
    do_start();
    wait_run();
    gen_ks(key2, '0, 4 * W);
    run_fixed(4, 1'b0);
    rst = 1'b0;
    #1;
    chk("arst_mvalid", m_valid, 0);
    chk("arst_mdata", m_data, 0);
    chk("arst_sready", s_ready, 0);
    chk("arst_err", err, 0);
    chk("arst_state", state_o, IDLE);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("arst_idle", state_o, IDLE);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
